branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Hardwired control-step sequencer that executes one conditional-branch instruction (fetch through PC update) on the Mini SRC datapath. It generates the bus and register strobes that are otherwise sequenced by hand. It evaluates all four branch conditions (brzr, brnz, brpl, brmi) internally from the bus instead of relying on an external CON flip-flop. It sits beside the datapath, drives its control inputs, and supports memory wait states.

## Interface
- DATA_WIDTH, 32, width of bus_data and ir_data
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a branch
- ALU_ADD, 5'b00011, alu_op code for addition
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- start  in  1  begin one instruction; sampled only in IDLE
- mem_ready  in  1  memory read data valid; extends T1
- bus_data  in  DATA_WIDTH  datapath bus (R[ra] during T3)
- ir_data  in  DATA_WIDTH  IR contents (valid from T3)
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, gra, r_out, y_in, c_out  out  1 each  datapath strobes
- alu_op  out  5  ALU operation select
- con_q  out  1  registered branch condition
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- illegal  out  1  one-cycle pulse when the opcode is not BR_OPCODE
- taken_cnt, not_taken_cnt  out  16 each  present only with BRANCH_STATS_EN

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Strobes are decoded combinationally from the state (Moore). In each state, only the listed strobes are high.
  - IDLE: no strobes.
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, read, mdr_in. pc_in is high only on the first T1 cycle.
  - T2: mdr_out, ir_in.
  - T3: gra, r_out.
  - T4: pc_out, y_in.
  - T5: c_out, z_in, alu_op=ALU_ADD. In all other states alu_op=0.
  - T6: zlow_out, and pc_in only if con_q=1.
- Transitions:
  - IDLE→T0 when start=1.
  - T0→T1.
  - T1 stays in T1 while mem_ready=0 and goes to T2 when mem_ready=1.
  - T2→T3.
  - T3→T4 if ir_data[31:27]==BR_OPCODE. Otherwise T3 pulses illegal and returns to IDLE.
  - T4→T5→T6→IDLE.
- Condition, registered into con_q at the end of T3 from C2=ir_data[22:19]:
  - C2[1:0]=00: bus_data==0.
  - 01: bus_data!=0.
  - 10: bus_data[DATA_WIDTH-1]==0.
  - 11: bus_data[DATA_WIDTH-1]==1.
  - C2[3:2] are ignored.
- con_q holds its value until the next T3.
- start outside IDLE is ignored. start held high in IDLE launches back-to-back instructions.

## Timing
- Reset values: state=IDLE; all strobes, alu_op, con_q, done, illegal and busy are 0; counters are 0.
- clr takes effect asynchronously: strobes drop in the same cycle and the sequencer re-enters IDLE.
- No wait states (mem_ready=1 in T1): start sampled at edge n, T0 in cycle n+1, T6 in cycle n+7, IDLE in cycle n+8.
- done is high during T6.
- Each low-mem_ready cycle in T1 adds exactly one cycle of latency.
- mem_ready is ignored outside T1.
- illegal is high during the failing T3 cycle. The state is IDLE the following cycle, and done is not asserted.
- bus_data must be stable by the T3 rising-edge setup time. con_q updates on that edge.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_cnt increments in T6 when con_q=1; not_taken_cnt increments in T6 when con_q=0.
  - Both counters saturate at 16'hFFFF and clear on clr.
- Not defined: both counter ports and all their logic are absent.

## Structure
- Shared package minisrc_ctrl_pkg holds:
  - the state enum;
  - the opcode constants (BR_OPCODE);
  - the ALU op constants (ALU_ADD);
  - the C2 condition codes (COND_ZR, COND_NZ, COND_PL, COND_MI).
- One sub-module: branch_cond_eval (combinational; inputs C2[1:0] and bus_data, output cond). It is reused later by the full control unit.

## Test plan
- brnz (C2=0001), bus_data=0 in T3 → con_q=0, pc_in low in T6, done at cycle n+7, not_taken_cnt=1.
- brnz, bus_data=32'h00000005 → con_q=1, pc_in and zlow_out high in T6, taken_cnt=1.
- brmi (C2=0011), bus_data=32'h80000000 → con_q=1; brpl with the same bus value → con_q=0.
- mem_ready held low for 3 cycles in T1 → T1 lasts 4 cycles, pc_in high only on the first T1 cycle, done at n+10.
- clr asserted mid-T4 → strobes 0 immediately, busy=0, con_q=0, counters 0; next start behaves exactly as after power-on.
- ir_data[31:27]=5'b00011 → illegal pulse in T3, no T4–T6 strobes, no done, IDLE next cycle.

Source files
------------

// File: rtl/minisrc_ctrl_pkg.sv
// Shared control definitions for the Mini SRC hardwired control logic:
// step-state encoding, opcode / ALU-op constants and branch condition codes.
package minisrc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  localparam logic [4:0] BR_OPCODE = 5'b10010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;

  // Low two bits of the C2 field select the branch condition.
  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: tests the bus value against the
// condition selected by C2[1:0] (zero, non-zero, plus, minus).
module branch_cond_eval #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            c2,
  input  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  cond
);
  import minisrc_ctrl_pkg::*;

  logic w_zero;
  logic w_neg;

  assign w_zero = (bus_data == '0);
  assign w_neg  = bus_data[DATA_WIDTH-1];

  always_comb begin
    cond = 1'b0;
    case (c2)
      COND_ZR: cond = w_zero;
      COND_NZ: cond = !w_zero;
      COND_PL: cond = !w_neg;
      COND_MI: cond = w_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Hardwired T0..T6 sequencer for one Mini SRC conditional branch, with memory
// wait states in T1. Optional taken/not-taken counters under BRANCH_STATS_EN.
module branch_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] BR_OPCODE  = minisrc_ctrl_pkg::BR_OPCODE,
  parameter logic [4:0] ALU_ADD    = minisrc_ctrl_pkg::ALU_ADD
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] bus_data,
  input  logic [DATA_WIDTH-1:0] ir_data,
  output logic                  pc_out,
  output logic                  mar_in,
  output logic                  inc_pc,
  output logic                  z_in,
  output logic                  zlow_out,
  output logic                  pc_in,
  output logic                  read,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in,
  output logic                  gra,
  output logic                  r_out,
  output logic                  y_in,
  output logic                  c_out,
  output logic [4:0]            alu_op,
  output logic                  con_q,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
`ifdef BRANCH_STATS_EN
  output logic [15:0]           taken_cnt,
  output logic [15:0]           not_taken_cnt,
`endif
  output logic [2:0]            dbg_state
);
  import minisrc_ctrl_pkg::*;

  state_t r_state;
  state_t w_next;
  logic   r_t1_wait;   // set once T1 has been extended by a wait state
  logic   r_con_q;
  logic   w_cond;
  logic   w_is_branch;
  logic   w_unused_ir;

  assign w_is_branch = (ir_data[31:27] == BR_OPCODE);
  assign w_unused_ir = ^ir_data;

  branch_cond_eval #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
    .c2       (ir_data[20:19]),
    .bus_data (bus_data),
    .cond     (w_cond)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_t1_wait <= 1'b0;
      r_con_q   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_t1_wait <= (r_state == S_T1) && !mem_ready;
      if (r_state == S_T3) r_con_q <= w_cond;
    end
  end

  always_comb begin
    w_next   = r_state;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    r_out    = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_op   = 5'd0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        // Only the first T1 cycle loads the incremented PC; wait cycles must not.
        zlow_out = 1'b1;
        pc_in    = !r_t1_wait;
        read     = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ready) w_next = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        gra   = 1'b1;
        r_out = 1'b1;
        if (w_is_branch) begin
          w_next = S_T4;
        end else begin
          illegal = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
        w_next = S_T5;
      end
      S_T5: begin
        c_out  = 1'b1;
        z_in   = 1'b1;
        alu_op = ALU_ADD;
        w_next = S_T6;
      end
      S_T6: begin
        zlow_out = 1'b1;
        pc_in    = r_con_q;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign con_q     = r_con_q;
  assign dbg_state = r_state;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_not_taken_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_taken_cnt     <= 16'd0;
      r_not_taken_cnt <= 16'd0;
    end else if (r_state == S_T6) begin
      if (r_con_q) begin
        if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
      end else begin
        if (r_not_taken_cnt != 16'hFFFF) r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
      end
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: table of branch vectors plus hand-written
// sequences for wait states, an illegal opcode and clr in the middle of T4.
module tb_branch_sequencer;
  import minisrc_ctrl_pkg::*;

  localparam int DW = 32;

  // Strobe order: pc_out mar_in inc_pc z_in zlow_out pc_in read mdr_in
  //               mdr_out ir_in gra r_out y_in c_out
  localparam logic [13:0] ST_NONE = 14'b00000000000000;
  localparam logic [13:0] ST_T0   = 14'b11110000000000;
  localparam logic [13:0] ST_T1F  = 14'b00001111000000;
  localparam logic [13:0] ST_T1W  = 14'b00001011000000;
  localparam logic [13:0] ST_T2   = 14'b00000000110000;
  localparam logic [13:0] ST_T3   = 14'b00000000001100;
  localparam logic [13:0] ST_T4   = 14'b10000000000010;
  localparam logic [13:0] ST_T5   = 14'b00010000000001;
  localparam logic [13:0] ST_T6T  = 14'b00001100000000;
  localparam logic [13:0] ST_T6N  = 14'b00001000000000;

  // Clock / reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic          start, mem_ready;
  logic [DW-1:0] bus_data, ir_data;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in;
  logic mdr_out, ir_in, gra, r_out, y_in, c_out;
  logic [4:0] alu_op;
  logic con_q, busy, done, illegal;
  logic [2:0] dbg_state;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, not_taken_cnt;
`endif

  branch_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready),
    .bus_data(bus_data), .ir_data(ir_data),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out),
    .y_in(y_in), .c_out(c_out), .alu_op(alu_op), .con_q(con_q),
    .busy(busy), .done(done), .illegal(illegal),
`ifdef BRANCH_STATS_EN
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt),
`endif
    .dbg_state(dbg_state)
  );

  logic [13:0] strb;
  assign strb = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
                 mdr_out, ir_in, gra, r_out, y_in, c_out};

  // Scoreboard counters
  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_taken = 16'd0;
  logic [15:0] exp_not_taken = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic [2:0] st, input logic [13:0] s,
                            input logic [4:0] op, input logic d, input logic b);
    check({tag, " state"},  {29'd0, dbg_state}, {29'd0, st});
    check({tag, " strobes"}, {18'd0, strb}, {18'd0, s});
    check({tag, " alu_op"},  {27'd0, alu_op}, {27'd0, op});
    check({tag, " done"},    {31'd0, done}, {31'd0, d});
    check({tag, " busy"},    {31'd0, busy}, {31'd0, b});
  endtask

  task automatic check_counters(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, " taken_cnt"},     {16'd0, taken_cnt},     {16'd0, exp_taken});
    check({tag, " not_taken_cnt"}, {16'd0, not_taken_cnt}, {16'd0, exp_not_taken});
`else
    tests_run += 0;
`endif
  endtask

  // Driver: one instruction from start to return to IDLE, checked every cycle.
  task automatic run_instr(input string tag, input logic [4:0] opc, input logic [3:0] c2,
                           input logic [DW-1:0] bus, input int waits, input logic exp_con);
    logic is_br;
    is_br = (opc == 5'b10010);
    @(negedge clk);
    start = 1'b1;
    ir_data = {opc, 4'b0000, c2, 19'h00000};
    bus_data = bus;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_step({tag, " T0"}, S_T0, ST_T0, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check_step({tag, " T1"}, S_T1, (k == 0) ? ST_T1F : ST_T1W, 5'd0, 1'b0, 1'b1);
      mem_ready = (k == waits);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check_step({tag, " T2"}, S_T2, ST_T2, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    check_step({tag, " T3"}, S_T3, ST_T3, 5'd0, 1'b0, 1'b1);
    check({tag, " T3 illegal"}, {31'd0, illegal}, {31'd0, !is_br});
    if (is_br) begin
      @(negedge clk);
      check_step({tag, " T4"}, S_T4, ST_T4, 5'd0, 1'b0, 1'b1);
      check({tag, " con_q"}, {31'd0, con_q}, {31'd0, exp_con});
      @(negedge clk);
      check_step({tag, " T5"}, S_T5, ST_T5, 5'b00011, 1'b0, 1'b1);
      @(negedge clk);
      check_step({tag, " T6"}, S_T6, exp_con ? ST_T6T : ST_T6N, 5'd0, 1'b1, 1'b1);
      if (exp_con) exp_taken++;
      else exp_not_taken++;
    end
    @(negedge clk);
    check_step({tag, " end"}, S_IDLE, ST_NONE, 5'd0, 1'b0, 1'b0);
    check({tag, " end illegal"}, {31'd0, illegal}, 32'd0);
    check_counters(tag);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  c2;
    logic [31:0] bus;
    logic        exp_con;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"brnz_zero",    4'b0001, 32'h00000000, 1'b0};
    vecs[1] = '{"brnz_five",    4'b0001, 32'h00000005, 1'b1};
    vecs[2] = '{"brmi_neg",     4'b0011, 32'h80000000, 1'b1};
    vecs[3] = '{"brpl_neg",     4'b0010, 32'h80000000, 1'b0};
    vecs[4] = '{"brzr_zero",    4'b0000, 32'h00000000, 1'b1};
    vecs[5] = '{"brzr_hi_c2",   4'b1100, 32'h00000007, 1'b0};
    vecs[6] = '{"brpl_maxpos",  4'b0010, 32'h7FFFFFFF, 1'b1};
    vecs[7] = '{"brmi_one",     4'b0011, 32'h00000001, 1'b0};
    vecs[8] = '{"brnz_hi_c2",   4'b1001, 32'hFFFFFFFF, 1'b1};

    clr = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    bus_data = '0;
    ir_data = '0;
    #2;
    check_step("reset", S_IDLE, ST_NONE, 5'd0, 1'b0, 1'b0);
    check("reset con_q", {31'd0, con_q}, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    check_counters("reset");
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i])
      run_instr(vecs[i].name, 5'b10010, vecs[i].c2, vecs[i].bus, 0, vecs[i].exp_con);

    run_instr("wait3", 5'b10010, 4'b0001, 32'h00000005, 3, 1'b1);
    run_instr("illegal", 5'b00011, 4'b0001, 32'h00000005, 0, 1'b0);
    run_instr("after_illegal", 5'b10010, 4'b0000, 32'h00000004, 0, 1'b0);

    // clr in the middle of T4 after a taken branch left con_q=1
    run_instr("pre_clr", 5'b10010, 4'b0001, 32'h00000001, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    ir_data = {5'b10010, 4'b0000, 4'b0001, 19'h00000};
    bus_data = 32'h00000009;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("clr pre state", {29'd0, dbg_state}, {29'd0, S_T4});
    clr = 1'b1;
    exp_taken = 16'd0;
    exp_not_taken = 16'd0;
    #1;
    check_step("clr", S_IDLE, ST_NONE, 5'd0, 1'b0, 1'b0);
    check("clr con_q", {31'd0, con_q}, 32'd0);
    check_counters("clr");
    @(negedge clk);
    clr = 1'b0;
    run_instr("post_clr", 5'b10010, 4'b0001, 32'h00000000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
